// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the parity helper
// used by both the transmitter and the receiver.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;

  // The state name is the bit currently being driven on the line.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic logic uart_parity(input logic [DATA_BITS-1:0] i_data);
    return ^i_data;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte valid/ready handshake between a producer (master) and the UART transmitter (slave).
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; circular pointers wrap at DEPTH (a power of two).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_push,
  input  logic                 i_pop,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_full,
  output logic                 o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wrPtr;
  logic [PTR_W-1:0]     r_rdPtr;
  logic [CNT_W-1:0]     r_count;
  logic                 w_doPush;
  logic                 w_doPop;

  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_data   = r_mem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Push and pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start(0), 8 data bits LSB first, even parity, stop(1), paced by baud_tick.
// Define UART_TX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     baud_tick,
  uart_tx_if.slave bus,
  output logic     tx,
  output logic     busy,
  output logic     tx_done
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_badDepth
    $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  uart_state_e          r_state;
  logic [DATA_BITS-1:0] r_shiftReg;
  logic [2:0]           r_bitCnt;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_txDone;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_pending;
  logic                 w_full;
  logic [DATA_BITS-1:0] w_popData;

  assign bus.in_ready = !rst && !w_full;
  assign w_push       = bus.in_valid && bus.in_ready;
  assign w_pop        = baud_tick && w_pending && (r_state == ST_IDLE || r_state == ST_STOP);

`ifdef UART_TX_FIFO_EN
  logic w_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_data  (bus.in_data),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .o_data  (w_popData),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pending = !w_empty;
`else
  logic                 r_holdFull;
  logic [DATA_BITS-1:0] r_holdData;

  // in_ready is low while full, so a push never coincides with a pop here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_holdFull <= 1'b0;
      r_holdData <= '0;
    end else if (w_pop) begin
      r_holdFull <= 1'b0;
    end else if (w_push) begin
      r_holdFull <= 1'b1;
      r_holdData <= bus.in_data;
    end
  end

  assign w_full    = r_holdFull;
  assign w_pending = r_holdFull;
  assign w_popData = r_holdData;
`endif

  // The byte is copied into r_shiftReg at pop, so the source slot is free afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shiftReg <= '0;
      r_bitCnt   <= '0;
      r_tx       <= STOP_LEVEL;
      r_busy     <= 1'b0;
      r_txDone   <= 1'b0;
    end else begin
      r_txDone <= 1'b0;
      if (baud_tick) begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_pending) begin
              r_shiftReg <= w_popData;
              r_tx       <= 1'b0;
              r_busy     <= 1'b1;
              r_state    <= ST_START;
            end else begin
              r_tx <= STOP_LEVEL;
            end
          end
          ST_START: begin
            r_tx     <= r_shiftReg[0];
            r_bitCnt <= '0;
            r_state  <= ST_DATA;
          end
          ST_DATA: begin
            if (r_bitCnt != 3'(DATA_BITS - 1)) begin
              r_tx     <= r_shiftReg[r_bitCnt + 3'd1];
              r_bitCnt <= r_bitCnt + 3'd1;
            end else begin
              r_tx    <= uart_parity(r_shiftReg);
              r_state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            r_tx    <= STOP_LEVEL;
            r_state <= ST_STOP;
          end
          ST_STOP: begin
            r_txDone <= 1'b1;
            if (w_pending) begin
              r_shiftReg <= w_popData;
              r_tx       <= 1'b0;
              r_state    <= ST_START;
            end else begin
              r_tx    <= STOP_LEVEL;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_tx    <= STOP_LEVEL;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign tx      = r_tx;
  assign busy    = r_busy;
  assign tx_done = r_txDone;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level reference model plus directed and random byte streams.
// Build with +define+UART_TX_FIFO_EN to exercise the FIFO variant.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_FIFO_EN
  localparam int CAP = FIFO_DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic baud_tick = 1'b0;
  logic tx;
  logic busy;
  logic tx_done;

  uart_tx_if bus ();

  uart_tx #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .bus       (bus),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail = 0;
  int doneCnt = 0;
  int tickCnt = 0;
  int tickPeriod = 16;
  bit tickEn = 1'b0;

  logic [7:0] mPending[$];
  logic       mFrame[$];
  logic       mTx = 1'b1;
  logic       mBusy = 1'b0;
  logic       mDone = 1'b0;
  logic       mAccepted = 1'b0;

  logic       capQ[$];
  logic [7:0] sent[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line image of one frame, bit i is the i-th bit on the wire.
  function automatic logic [10:0] expectedFrame(input logic [7:0] b);
    return {1'b1, ^b, b, 1'b0};
  endfunction

  function automatic int findStart(input int from);
    for (int i = from; i < capQ.size(); i++) begin
      if (capQ[i] == 1'b0) return i;
    end
    return -1;
  endfunction

  function automatic logic [10:0] frameAt(input int s);
    logic [10:0] f;
    f = '1;
    for (int i = 0; i < 11; i++) begin
      if (s + i >= 0 && s + i < capQ.size()) f[i] = capQ[s + i];
      else f[i] = 1'bx;
    end
    return f;
  endfunction

  // Reference model: each tick emits the next bit of the current frame, or starts a new one.
  always @(posedge clk or posedge rst) begin : refModel
    logic [7:0]  popByte;
    logic [10:0] frame;
    logic        accept;
    if (rst) begin
      mPending.delete();
      mFrame.delete();
      mTx = 1'b1;
      mBusy = 1'b0;
      mDone = 1'b0;
      mAccepted = 1'b0;
    end else begin
      accept = bus.in_valid && (mPending.size() < CAP);
      mAccepted = accept;
      mDone = 1'b0;
      if (baud_tick) begin
        if (mFrame.size() == 0) begin
          mDone = mBusy;
          if (mPending.size() != 0) begin
            popByte = mPending.pop_front();
            frame = expectedFrame(popByte);
            for (int i = 0; i < 11; i++) mFrame.push_back(frame[i]);
          end
        end
        if (mFrame.size() != 0) begin
          mTx = mFrame.pop_front();
          mBusy = 1'b1;
        end else begin
          mTx = 1'b1;
          mBusy = 1'b0;
        end
      end
      if (accept) mPending.push_back(bus.in_data);
    end
  end

  always @(posedge clk) begin
    #2;
    checkOutput("tx", tx, mTx);
    checkOutput("busy", busy, mBusy);
    checkOutput("tx_done", tx_done, mDone);
    checkOutput("in_ready", bus.in_ready, !rst && (mPending.size() < CAP));
    if (baud_tick && !rst) capQ.push_back(tx);
    if (tx_done) doneCnt++;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!tickEn) begin
        baud_tick = 1'b0;
        tickCnt = 0;
      end else if (tickCnt >= tickPeriod - 1) begin
        baud_tick = 1'b1;
        tickCnt = 0;
      end else begin
        baud_tick = 1'b0;
        tickCnt++;
      end
    end
  end

  // Called on a negedge; returns on a negedge with in_valid low.
  task automatic applyStimulus(input logic [7:0] b);
    bus.in_data = b;
    bus.in_valid = 1'b1;
    sent.push_back(b);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (mAccepted) break;
    end
    if (!mAccepted) checkOutput("accept_timeout", 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data = 8'($urandom);
  endtask

  task automatic waitIdle(input string tag);
    bit idle = 1'b0;
    for (int i = 0; i < 4000 && !idle; i++) begin
      @(posedge clk);
      #1;
      idle = (mPending.size() == 0) && (mFrame.size() == 0) && !mBusy;
    end
    if (!idle) checkOutput({tag, "_idle_timeout"}, 0, 1);
    @(negedge clk);
  endtask

  // Receiver model: decode every frame on the captured line and match it against sent bytes.
  task automatic checkDecoded(input string tag);
    int idx;
    int s;
    logic [7:0] d;
    idx = 0;
    foreach (sent[k]) begin
      s = findStart(idx);
      if (s < 0 || s + 11 > capQ.size()) begin
        checkOutput({tag, "_frame_missing"}, 0, 1);
        return;
      end
      for (int i = 0; i < 8; i++) d[i] = capQ[s + 1 + i];
      checkOutput({tag, "_data"}, d, sent[k]);
      checkOutput({tag, "_parity"}, capQ[s + 9], ^sent[k]);
      checkOutput({tag, "_stop"}, capQ[s + 10], 1);
      idx = s + 11;
    end
  endtask

  initial begin : watchdog
    #800000;
    checkOutput("watchdog", 0, 1);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin : main
    int s;
    int done0;
    int zeros;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;

    repeat (3) @(negedge clk);
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_tx_done", tx_done, 0);
    checkOutput("rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", bus.in_ready, 1);

`ifdef UART_TX_FIFO_EN
    tickEn = 1'b0;
    sent.delete();
    capQ.delete();
    for (int v = 8'h11; v <= 8'h14; v++) applyStimulus(8'(v));
    checkOutput("fifo_full_ready", bus.in_ready, 0);
    tickPeriod = 16;
    tickEn = 1'b1;
    applyStimulus(8'h15);
    waitIdle("fifo");
    checkDecoded("fifo");
`endif

    tickPeriod = 16;
    tickEn = 1'b1;

    sent.delete();
    capQ.delete();
    done0 = doneCnt;
    applyStimulus(8'hA5);
    waitIdle("a5");
    s = findStart(0);
    checkOutput("a5_frame", frameAt(s), 11'h54A);
    checkOutput("a5_done_count", doneCnt - done0, 1);
    checkOutput("a5_busy_after", busy, 0);

    sent.delete();
    capQ.delete();
    applyStimulus(8'h01);
    waitIdle("x01");
    s = findStart(0);
    checkOutput("x01_frame", frameAt(s), 11'h602);

    sent.delete();
    capQ.delete();
    done0 = doneCnt;
    applyStimulus(8'h3C);
    applyStimulus(8'hC3);
`ifndef UART_TX_FIFO_EN
    checkOutput("b2b_ready_low", bus.in_ready, 0);
`endif
    waitIdle("b2b");
    s = findStart(0);
    checkOutput("b2b_frame1", frameAt(s), expectedFrame(8'h3C));
    checkOutput("b2b_frame2_no_gap", frameAt(s + 11), expectedFrame(8'hC3));
    checkOutput("b2b_done_count", doneCnt - done0, 2);

    sent.delete();
    capQ.delete();
    applyStimulus(8'hFF);
    applyStimulus(8'h55);
    s = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      s = findStart(0);
      if (s >= 0 && capQ.size() >= s + 5) break;
    end
    checkOutput("ff_reached_bit3", (s >= 0 && capQ.size() >= s + 5), 1);
    rst = 1'b1;
    #1;
    checkOutput("midframe_rst_tx", tx, 1);
    checkOutput("midframe_rst_busy", busy, 0);
    checkOutput("midframe_rst_ready", bus.in_ready, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    capQ.delete();
    done0 = doneCnt;
    repeat (120) @(negedge clk);
    zeros = 0;
    foreach (capQ[i]) if (capQ[i] == 1'b0) zeros++;
    checkOutput("post_rst_ticks_seen", capQ.size() >= 5, 1);
    checkOutput("post_rst_line_idle", zeros, 0);
    checkOutput("post_rst_no_done", doneCnt - done0, 0);
    checkOutput("post_rst_busy", busy, 0);

    sent.delete();
    capQ.delete();
    for (int n = 0; n < 25; n++) begin
      tickPeriod = $urandom_range(2, 6);
      applyStimulus((n == 0) ? 8'h7E : 8'($urandom));
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    waitIdle("rand");
    checkDecoded("rand");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
